// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic valid/ready pipeline-stage register holding DEPTH entries with flush-to-bubble.
// Optional stall/full cycle counters are enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  full_cnt
`endif
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign in_ready  = count_q != CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : BUBBLE;
  assign count     = count_q;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Next-state: flush clears everything to bubbles; otherwise write at wr_ptr and advance wrapping pointers.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = flush ? BUBBLE : mem_q[i];
    if (push) mem_d[wr_ptr_q] = in_data;
    wr_ptr_d = flush ? '0 : !push ? wr_ptr_q : (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = flush ? '0 : !pop ? rd_ptr_q : (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end

  // Storage, pointers and occupancy registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '{default: BUBBLE};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, full_cnt_q, full_cnt_d;

  assign stall_cnt = stall_cnt_q;
  assign full_cnt  = full_cnt_q;

  // Saturating counters: downstream stalls (flush cycles excluded) and upstream blocked by full.
  always_comb begin
    stall_cnt_d = (out_valid & ~out_ready & ~flush & ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    full_cnt_d  = (in_valid & ~in_ready & ~&full_cnt_q) ? full_cnt_q + 1'b1 : full_cnt_q;
  end

  // Counters are cleared only by reset, never by flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
      full_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      full_cnt_q  <= full_cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed table-driven bench for pipe_stage_buf (DEPTH=2) plus a DEPTH=3 wrap sequence.
module tb_pipe_stage_buf;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        a_flush = 0, a_iv = 0, a_or = 0, a_ir, a_ov;
  logic [31:0] a_d = 0, a_od;
  logic [1:0]  a_cnt;
  logic        b_flush = 0, b_iv = 0, b_or = 0, b_ir, b_ov;
  logic [31:0] b_d = 0, b_od;
  logic [1:0]  b_cnt;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0] a_stall, a_full, b_stall, b_full;
`endif

  pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .BUBBLE(32'h0)) dut_a (
    .clk(clk), .rstn(rstn), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .count(a_cnt)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cnt(a_stall), .full_cnt(a_full)
`endif
  );

  pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .BUBBLE(32'h0)) dut_b (
    .clk(clk), .rstn(rstn), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_d),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .count(b_cnt)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cnt(b_stall), .full_cnt(b_full)
`endif
  );

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        orr;
    logic        ev;
    logic        er;
    logic [31:0] ed;
    logic [1:0]  ec;
  } vec_t;

  vec_t        tv[$];
  int          tests = 0, fails = 0;
  int          sent, got, mc, cyc;
  logic        pu, po;
  logic [31:0] q[$];
  logic [31:0] s0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic add(input logic fl, iv, input logic [31:0] d, input logic orr,
                     input logic ev, er, input logic [31:0] ed, input logic [1:0] ec);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.orr = orr; v.ev = ev; v.er = er; v.ed = ed; v.ec = ec;
    tv.push_back(v);
  endtask

  task automatic step_a(input logic fl, iv, input logic [31:0] d, input logic orr);
    @(negedge clk);
    a_flush = fl; a_iv = iv; a_d = d; a_or = orr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // back-pressure: 11, 22 fill; 33 ignored; drain
    add(0, 1, 32'h11, 0, 1, 1, 32'h11, 1);
    add(0, 1, 32'h22, 0, 1, 0, 32'h11, 2);
    add(0, 1, 32'h33, 0, 1, 0, 32'h11, 2);
    add(0, 0, 32'h0,  1, 1, 1, 32'h22, 1);
    add(0, 0, 32'h0,  1, 0, 1, 32'h0,  0);
    // empty ignores out_ready
    add(0, 0, 32'h0,  1, 0, 1, 32'h0,  0);
    // streaming 1..8 then drain
    for (int k = 1; k <= 8; k++) add(0, 1, k, 1, 1, 1, k, 1);
    add(0, 0, 32'h0, 1, 0, 1, 32'h0, 0);
    // flush with same-cycle push of 55, then 66 emerges first
    add(0, 1, 32'h44, 0, 1, 1, 32'h44, 1);
    add(0, 1, 32'h45, 0, 1, 0, 32'h44, 2);
    add(1, 1, 32'h55, 0, 0, 1, 32'h0,  0);
    add(0, 1, 32'h66, 0, 1, 1, 32'h66, 1);
    add(0, 0, 32'h0,  1, 0, 1, 32'h0,  0);
    // full with pop: push blocked, pop happens
    add(0, 1, 32'h71, 0, 1, 1, 32'h71, 1);
    add(0, 1, 32'h72, 0, 1, 0, 32'h71, 2);
    add(0, 1, 32'h73, 1, 1, 1, 32'h72, 1);
    add(0, 0, 32'h0,  1, 0, 1, 32'h0,  0);

    // reset held 3 cycles with a live input
    a_iv = 1; a_d = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", a_ov, 0);
    chk("rst_data", a_od, 0);
    chk("rst_count", a_cnt, 0);
    chk("rst_ready", a_ir, 1);
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    #1;
    chk("post_rst_data", a_od, 32'hDEAD_BEEF);
    chk("post_rst_count", a_cnt, 1);
    step_a(0, 0, 0, 1);
    chk("post_rst_drain", a_cnt, 0);

    foreach (tv[i]) begin
      step_a(tv[i].fl, tv[i].iv, tv[i].d, tv[i].orr);
      chk($sformatf("v%0d_valid", i), a_ov, tv[i].ev);
      chk($sformatf("v%0d_ready", i), a_ir, tv[i].er);
      chk($sformatf("v%0d_data", i), a_od, tv[i].ed);
      chk($sformatf("v%0d_count", i), a_cnt, tv[i].ec);
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    step_a(0, 1, 32'h99, 0);
    s0 = a_stall;
    repeat (5) step_a(0, 0, 0, 0);
    chk("stall_cnt_5", a_stall - s0, 5);
    step_a(1, 0, 0, 0);
    chk("stall_cnt_flush_keep", a_stall - s0, 5);
`endif

    // DEPTH=3 wrap with random out_ready against a queue model
    sent = 0; got = 0; mc = 0; cyc = 0;
    while (got < 10 && cyc < 300) begin
      @(negedge clk);
      b_iv = sent < 10;
      b_d  = 32'h100 + sent;
      b_or = ($urandom_range(0, 2) == 0);
      pu = b_iv && mc != 3;
      po = b_or && mc != 0;
      chk("wrap_ready", b_ir, mc != 3);
      @(posedge clk);
      #1;
      if (po) begin void'(q.pop_front()); got++; end
      if (pu) begin q.push_back(b_d); sent++; end
      mc = q.size();
      chk("wrap_count", b_cnt, mc);
      chk("wrap_data", b_od, mc != 0 ? q[0] : 32'h0);
      chk("wrap_max", b_cnt <= 3, 1);
      cyc++;
    end
    if (got < 10) chk("wrap_timeout", got, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised elastic pipeline-stage register. It replaces the fixed-field advance/flush/hold stage registers with one generic block that uses a valid/ready handshake and holds DEPTH entries. It sits between any two pipeline stages (F/D, D/E, E/W); the caller packs that stage's fields into one WIDTH-bit bus. Flush inserts bubbles, and a full buffer back-pressures upstream without any combinational ready path.

Parameters:
- WIDTH, 32: payload width in bits (1..1024).
- DEPTH, 2: number of entries (1..4). DEPTH=1 is a plain stage register with stall/flush.
- BUBBLE, 0 (WIDTH bits): value driven on out_data when empty, after reset and after flush. It encodes the stage's no-op, e.g. inst=1 or FUNC_NOTHING.

Ports:
- clk, in, 1: clock, rising edge.
- rstn, in, 1: reset, asynchronous, active-low.
- flush, in, 1: synchronous flush; discards all entries.
- in_valid, in, 1: upstream presents in_data.
- in_ready, out, 1: buffer can accept this cycle.
- in_data, in, WIDTH: upstream payload.
- out_valid, out, 1: head entry is valid.
- out_ready, in, 1: downstream consumes the head this cycle.
- out_data, out, WIDTH: head entry payload, or BUBBLE when empty.
- count, out, $clog2(DEPTH+1): current occupancy.

Behaviour:
- Storage: circular buffer of DEPTH entries with rd_ptr/wr_ptr. Each pointer wraps explicitly to 0 after DEPTH-1, so non-power-of-two DEPTH (3) works. count is held in a register.
- Reset (rstn=0, asynchronous):
  - count=0, pointers=0, every entry=BUBBLE.
  - out_valid=0, in_ready=1, out_data=BUBBLE.
  - Takes effect immediately, including mid-transfer. Release is synchronous to clk.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH). It is derived only from registered state; there is no combinational path from out_ready.
- out_valid = (count != 0). out_data = entry[rd_ptr] when out_valid, else BUBBLE.
- Latency: data pushed at edge N appears on out_data/out_valid after edge N. Minimum latency is 1 cycle, with no bypass.
- Throughput: push and pop in the same cycle leaves count unchanged. Both pointers advance. Full rate is sustained for DEPTH>=2.
  - DEPTH=1: a full entry blocks a push in the same cycle as its pop, so max rate is 1/2.
  - The team accepts this; use DEPTH>=2 on the critical stages.
- Full: in_ready=0 and in_data is ignored. Held entries are stable, and out_data is unchanged while out_ready=0 (hold).
- Empty: out_ready is ignored and count never underflows.
- Flush (priority over push/pop):
  - At the edge, count=0, rd_ptr=wr_ptr=0, and every entry is rewritten to BUBBLE.
  - A same-cycle in_valid is discarded.
  - out_valid=0 from the next cycle.
  - Flush while empty is a no-op apart from the pointer reset.
- Entries freed by a pop need not be rewritten. out_data is masked to BUBBLE whenever empty.

Optional Feature:
Macro PIPE_STAGE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [31:0], counting cycles where out_valid & ~out_ready & ~flush.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rstn only, not by flush.
  - Also adds output full_cnt [31:0], counting cycles where in_valid & ~in_ready. Same saturation and reset rules.
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
1. Reset: hold rstn=0 for 3 cycles with in_valid=1 and in_data=32'hDEAD_BEEF -> out_valid=0, out_data=0, count=0, in_ready=1. Deassert rstn mid-cycle, then push once -> out_data=32'hDEAD_BEEF one cycle later.
2. Back-pressure, DEPTH=2: out_ready=0, push 32'h11 then 32'h22 -> count=2 and in_ready=0. A third push of 32'h33 is ignored. Raise out_ready -> pops 32'h11 then 32'h22; 32'h33 is never seen.
3. Streaming: in_valid=1 and out_ready=1 for 8 cycles with data 1..8 -> out_data is 1..8 on consecutive cycles at 1-cycle latency, and count stays 1.
4. Flush: fill 2 entries, assert flush together with in_valid=1 carrying 32'h55 -> next cycle count=0, out_valid=0, out_data=BUBBLE. 32'h55 is lost. The next push of 32'h66 emerges first.
5. Wrap, DEPTH=3: push/pop 10 items with random out_ready -> order is preserved across pointer wrap, and count never exceeds 3.
6. With PIPE_STAGE_STALL_CNT_EN: hold out_valid=1 and out_ready=0 for 5 cycles -> stall_cnt=5. A flush does not clear it. A preloaded counter at 32'hFFFF_FFFF stays at that value.
